cute_lock_seq_ctrl: RTL
=======================

Name: cute_lock_seq_ctrl

Overview:
- Time-based key sequencer that sits between a wrapped benchmark FSM and the chip pins.
- Checks a multi-cycle key sequence (one key word per step) against a hard-wired schedule.
- Holds the wrapped FSM in reset until the first key word is accepted.
- Passes the FSM outputs through cleanly only after the full sequence matches; otherwise it releases the FSM but XOR-corrupts its outputs.
- Counts failed attempts and enforces permanent lockout after MAX_TRIES failures.

Parameters:
- KEY_W, 8, width of one key word.
- NUM_STEPS, 4, number of key words in the sequence (1..16).
- KEY_SCHEDULE, 32'h0F_F0_3C_A5, NUM_STEPS*KEY_W bits; step i is bits [i*KEY_W +: KEY_W].
- OUT_W, 20, width of the wrapped FSM output bus.
- CORRUPT_MASK, 20'hA5A5A, XOR mask applied to outputs when not unlocked.
- TIMEOUT, 8, maximum consecutive idle (key_valid=0) cycles allowed inside CHECK.
- MAX_TRIES, 3, failed attempts before permanent lockout.

Ports:
- clk, input, 1, clock; all registers update on the falling edge of clk (same edge as the wrapped FSMs).
- rst, input, 1, asynchronous active-low reset.
- key_in, input, KEY_W, key word for the current step.
- key_valid, input, 1, key_in is presented this cycle.
- key_restart, input, 1, abandon the current attempt and restart at step 0.
- fsm_y, input, OUT_W, raw outputs of the wrapped FSM.
- fsm_rst, output, 1, active-high reset to the wrapped FSM.
- y_out, output, OUT_W, gated outputs to the pins.
- unlocked, output, 1, full sequence accepted.
- lockout, output, 1, attempt budget exhausted.
- step_idx, output, 4, index of the next expected key word.
- fail_cnt, output, 2, failed attempts so far; saturates at MAX_TRIES.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, step_idx=0, idle_cnt=0, fail_cnt=0.
  - unlocked=0, lockout=0, fsm_rst=1.
  - y_out=0 whenever state=IDLE.
- States: IDLE, CHECK, UNLOCKED, BAD, LOCKOUT.
- A match means key_in == KEY_SCHEDULE word[step_idx].
- IDLE:
  - fsm_rst=1, y_out=0.
  - key_valid with a match: step_idx=1; go to UNLOCKED if NUM_STEPS==1, else CHECK.
  - key_valid with a mismatch: fail.
  - No key_valid: remain in IDLE.
- CHECK:
  - fsm_rst=0, y_out = fsm_y ^ CORRUPT_MASK.
  - key_valid with a match: step_idx+1 and idle_cnt=0. If the accepted word was step NUM_STEPS-1, go to UNLOCKED.
  - key_valid with a mismatch: fail.
  - key_valid=0: idle_cnt+1. When idle_cnt reaches TIMEOUT (idle cycle number TIMEOUT), fail.
- Fail action:
  - fail_cnt+1 (saturating), step_idx=0, idle_cnt=0.
  - If the new fail_cnt == MAX_TRIES, go to LOCKOUT; else go to BAD.
- BAD:
  - fsm_rst=0, y_out = fsm_y ^ CORRUPT_MASK.
  - key_in is ignored.
  - key_restart goes to IDLE (fsm_rst reasserts on the next cycle).
- UNLOCKED:
  - fsm_rst=0, y_out=fsm_y, unlocked=1.
  - key_in, key_valid and key_restart are all ignored; the state persists until rst.
- LOCKOUT:
  - fsm_rst=0, y_out = fsm_y ^ CORRUPT_MASK, lockout=1.
  - All inputs are ignored; only rst exits.
- key_restart in CHECK:
  - Go to IDLE with step_idx=0 and idle_cnt=0.
  - fail_cnt is not incremented.
- Simultaneous events:
  - key_restart has priority over key_valid in the same cycle.
  - A match on the last step has priority over timeout.
- Output timing:
  - y_out is combinational from fsm_y and the registered state; there is no added latency once unlocked.
  - unlocked, lockout, fsm_rst and step_idx are registered and change one clk falling edge after the deciding input.
- Reset mid-sequence returns to IDLE and clears fail_cnt, so the full attempt budget is restored.

Test Plan:
1. Defaults; after reset, key_valid=1 with key_in A5, 3C, F0, 0F on consecutive cycles -> step_idx 1,2,3 then unlocked=1. fsm_rst drops after the first edge. y_out==fsm_y (e.g. fsm_y=20'h00040 gives y_out=20'h00040).
2. Sequence A5, 3C, 00 -> BAD, fail_cnt=1, step_idx=0, unlocked=0. fsm_y=20'h00000 gives y_out=20'hA5A5A.
3. A5 followed by 8 cycles with key_valid=0 -> timeout on the 8th idle cycle, BAD, fail_cnt=1. A5, then 7 idle cycles, then 3C -> step_idx=2 with no failure.
4. Three failed attempts, each followed by key_restart -> lockout=1, fail_cnt=3. A subsequent correct sequence A5, 3C, F0, 0F leaves unlocked=0. rst low clears lockout and fail_cnt.
5. In CHECK at step_idx=2, key_restart=1 and key_valid=1 with key_in=F0 in the same cycle -> IDLE, step_idx=0, fail_cnt unchanged.
6. rst asserted low between clk edges while in UNLOCKED -> unlocked=0, fsm_rst=1 and y_out=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/cute_lock_seq_ctrl.sv
// Time-based key sequencer guarding a wrapped benchmark FSM.
// A multi-cycle key sequence is checked against a hard-wired schedule. The wrapped FSM is
// held in reset until the first word matches. Its outputs are corrupted with a fixed XOR mask
// until the whole sequence has been accepted. Failed attempts are counted, and a permanent
// lockout is entered once the attempt budget is spent.
// All state updates on the falling clock edge, the same edge the wrapped FSMs use.
module cute_lock_seq_ctrl #(
  parameter int unsigned                KEY_W        = 8,
  parameter int unsigned                NUM_STEPS    = 4,
  parameter logic [NUM_STEPS*KEY_W-1:0] KEY_SCHEDULE = 32'h0F_F0_3C_A5,
  parameter int unsigned                OUT_W        = 20,
  parameter logic [OUT_W-1:0]           CORRUPT_MASK = 20'hA5A5A,
  parameter int unsigned                TIMEOUT      = 8,
  parameter int unsigned                MAX_TRIES    = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [KEY_W-1:0] key_in_i,
  input  logic             key_valid_i,
  input  logic             key_restart_i,
  input  logic [OUT_W-1:0] fsm_y_i,
  output logic             fsm_rst_o,
  output logic [OUT_W-1:0] y_out_o,
  output logic             unlocked_o,
  output logic             lockout_o,
  output logic [3:0]       step_idx_o,
  output logic [1:0]       fail_cnt_o
);

  localparam int unsigned IdleW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StUnlocked,
    StBad,
    StLockout
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       step_idx_q, step_idx_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic [1:0]       fail_cnt_q, fail_cnt_d;
  logic             unlocked_q, unlocked_d;
  logic             lockout_q, lockout_d;
  logic             fsm_rst_q, fsm_rst_d;

  logic [KEY_W-1:0] sched [16];
  logic [KEY_W-1:0] sched_word;
  logic             key_match;
  logic             do_fail;
  logic [1:0]       fail_inc;

  // Unpack the schedule into words; unused slots read as zero and are never selected.
  for (genvar i = 0; i < 16; i++) begin : g_sched
    if (i < NUM_STEPS) begin : g_used
      assign sched[i] = KEY_SCHEDULE[i*KEY_W +: KEY_W];
    end else begin : g_unused
      assign sched[i] = '0;
    end
  end

  assign sched_word = sched[step_idx_q];
  assign key_match  = (key_in_i == sched_word);

  // Saturating increment of the failure counter.
  assign fail_inc = (fail_cnt_q == 2'(MAX_TRIES)) ? fail_cnt_q : fail_cnt_q + 2'd1;

  // Next-state decision; key_restart wins over key_valid in the same cycle.
  always_comb begin
    state_d    = state_q;
    step_idx_d = step_idx_q;
    idle_cnt_d = idle_cnt_q;
    fail_cnt_d = fail_cnt_q;
    do_fail    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (key_restart_i) begin
          step_idx_d = 4'd0;
          idle_cnt_d = '0;
        end else if (key_valid_i) begin
          if (key_match) begin
            step_idx_d = 4'd1;
            idle_cnt_d = '0;
            state_d    = (NUM_STEPS == 1) ? StUnlocked : StCheck;
          end else begin
            do_fail = 1'b1;
          end
        end
      end

      StCheck: begin
        if (key_restart_i) begin
          state_d    = StIdle;
          step_idx_d = 4'd0;
          idle_cnt_d = '0;
        end else if (key_valid_i) begin
          if (key_match) begin
            step_idx_d = step_idx_q + 4'd1;
            idle_cnt_d = '0;
            if (step_idx_q == 4'(NUM_STEPS - 1)) begin
              state_d = StUnlocked;
            end
          end else begin
            do_fail = 1'b1;
          end
        end else if (idle_cnt_q == IdleW'(TIMEOUT - 1)) begin
          // This idle cycle is number TIMEOUT.
          do_fail = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end

      StBad: begin
        if (key_restart_i) begin
          state_d = StIdle;
        end
      end

      StUnlocked, StLockout: begin
        // Terminal until reset.
      end

      default: begin
        state_d    = StIdle;
        step_idx_d = 4'd0;
        idle_cnt_d = '0;
      end
    endcase

    if (do_fail) begin
      fail_cnt_d = fail_inc;
      step_idx_d = 4'd0;
      idle_cnt_d = '0;
      state_d    = (fail_inc == 2'(MAX_TRIES)) ? StLockout : StBad;
    end
  end

  // Status outputs are decoded from the next state so they land on the same edge as the state.
  always_comb begin
    unlocked_d = (state_d == StUnlocked);
    lockout_d  = (state_d == StLockout);
    fsm_rst_d  = (state_d == StIdle);
  end

  // State and registered outputs, falling-edge clocked with asynchronous active-low reset.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      step_idx_q <= 4'd0;
      idle_cnt_q <= '0;
      fail_cnt_q <= 2'd0;
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
      fsm_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      step_idx_q <= step_idx_d;
      idle_cnt_q <= idle_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      unlocked_q <= unlocked_d;
      lockout_q  <= lockout_d;
      fsm_rst_q  <= fsm_rst_d;
    end
  end

  // Output gating is combinational so unlocked outputs follow fsm_y with no added latency.
  always_comb begin
    unique case (state_q)
      StIdle:     y_out_o = '0;
      StUnlocked: y_out_o = fsm_y_i;
      default:    y_out_o = fsm_y_i ^ CORRUPT_MASK;
    endcase
  end

  assign fsm_rst_o  = fsm_rst_q;
  assign unlocked_o = unlocked_q;
  assign lockout_o  = lockout_q;
  assign step_idx_o = step_idx_q;
  assign fail_cnt_o = fail_cnt_q;

endmodule
